// File: rtl/debug_tx_framer_if.sv
// Handshake bundle between the debug core / uart_tx and the debug frame serializer.
interface debug_tx_framer_if #(
  parameter int NB_DATA = 32,
  parameter int NB_BYTE = 8
);
  logic               i_send;
  logic [NB_DATA-1:0] i_pc;
  logic [NB_DATA-1:0] i_instruction;
  logic [NB_DATA-1:0] i_data;
  logic               i_tx_done_tick;
  logic               o_tx_start;
  logic [NB_BYTE-1:0] o_tx_data;
  logic               o_busy;
  logic               o_done;

  modport master (
    output i_send, i_pc, i_instruction, i_data, i_tx_done_tick,
    input  o_tx_start, o_tx_data, o_busy, o_done
  );

  modport slave (
    input  i_send, i_pc, i_instruction, i_data, i_tx_done_tick,
    output o_tx_start, o_tx_data, o_busy, o_done
  );
endinterface

// File: rtl/debug_tx_framer.sv
// Snapshots PC/instruction/data and streams a header+payload+XOR-checksum frame to uart_tx.
module debug_tx_framer #(
  parameter int                NB_DATA = 32,
  parameter int                NB_BYTE = 8,
  parameter logic [NB_BYTE-1:0] HEADER = 8'hA5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  debug_tx_framer_if.slave  bus
);
  localparam int         NPAY = 3 * NB_DATA / NB_BYTE;
  localparam logic [3:0] LAST = 4'(NPAY + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t                         state;
  logic [3:0]                     byte_idx;
  logic [NPAY-1:0][NB_BYTE-1:0]   snap;
  logic [NPAY-1:0][NB_BYTE-1:0]   snap_in;
  logic [NB_BYTE-1:0]             csum;
  logic [NB_BYTE-1:0]             csum_in;
  logic [NB_BYTE-1:0]             next_byte;
  logic [3:0]                     nidx;

  // Element NPAY-1 is PC MSB, so payload byte k (1-based) lives at index NPAY-k.
  assign snap_in = {bus.i_pc, bus.i_instruction, bus.i_data};

  always_comb begin
    csum_in = '0;
    for (int i = 0; i < NPAY; i++) csum_in = csum_in ^ snap_in[i];
  end

  always_comb begin
    nidx      = byte_idx + 4'd1;
    next_byte = csum;
    if (nidx != LAST) next_byte = snap[4'(NPAY) - nidx];
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state          <= IDLE;
      byte_idx       <= '0;
      snap           <= '0;
      csum           <= '0;
      bus.o_tx_start <= 1'b0;
      bus.o_tx_data  <= '0;
      bus.o_busy     <= 1'b0;
      bus.o_done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.o_done <= 1'b0;
          if (bus.i_send) begin
            snap           <= snap_in;
            csum           <= csum_in;
            byte_idx       <= '0;
            bus.o_tx_data  <= HEADER;
            bus.o_tx_start <= 1'b1;
            bus.o_busy     <= 1'b1;
            state          <= START;
          end
        end
        START: begin
          bus.o_tx_start <= 1'b0;
          state          <= WAIT;
        end
        WAIT: begin
          if (bus.i_tx_done_tick) begin
            if (byte_idx == LAST) begin
              bus.o_busy <= 1'b0;
              bus.o_done <= 1'b1;
              state      <= DONE;
            end else begin
              byte_idx       <= nidx;
              bus.o_tx_data  <= next_byte;
              bus.o_tx_start <= 1'b1;
              state          <= START;
            end
          end
        end
        DONE: begin
          bus.o_done <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_debug_tx_framer.sv
// Scoreboard bench: stimulus queues expected bytes/done markers, a negedge monitor pops and compares.
module tb_debug_tx_framer;
  localparam int DONE_MARK = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mdl_tick = 1'b0;
  logic inj_tick = 1'b0;
  int   mdl_cnt = 0;
  int   starts = 0;
  int   checks = 0;
  int   passes = 0;
  int   exp_q[$];
  logic [7:0] last_byte = 8'h00;

  debug_tx_framer_if #(.NB_DATA(32), .NB_BYTE(8)) bus();

  assign bus.i_tx_done_tick = mdl_tick | inj_tick;

  debug_tx_framer #(.NB_DATA(32), .NB_BYTE(8), .HEADER(8'hA5)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    checks++;
    $display("FAIL %s: got timeout/unexpected event expected none", name);
  endtask

  // uart_tx stand-in: done tick 16 cycles after each start pulse
  always @(negedge clk) begin
    if (rst) begin
      mdl_cnt  = 0;
      mdl_tick = 1'b0;
    end else begin
      mdl_tick = 1'b0;
      if (mdl_cnt != 0) begin
        mdl_cnt = mdl_cnt - 1;
        if (mdl_cnt == 0) mdl_tick = 1'b1;
      end
      if (bus.o_tx_start) mdl_cnt = 16;
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    int e;
    if (rst) begin
      exp_q.delete();
      starts = 0;
    end else begin
      if (bus.o_tx_start) begin
        starts++;
        last_byte = bus.o_tx_data;
        if (exp_q.size() == 0) fail("unexpected_start");
        else begin
          e = exp_q.pop_front();
          check("tx_byte", int'(bus.o_tx_data), e);
        end
      end
      if (bus.o_done) begin
        check("starts_per_frame", starts, 14);
        starts = 0;
        if (exp_q.size() == 0) fail("unexpected_done");
        else begin
          e = exp_q.pop_front();
          check("done_position", e, DONE_MARK);
        end
      end
      if (mdl_tick) check("tx_data_hold", int'(bus.o_tx_data), int'(last_byte));
    end
  end

  task automatic push_frame(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] dat);
    logic [95:0] p;
    logic [7:0]  b;
    logic [7:0]  x;
    p = {pc, ins, dat};
    x = 8'h00;
    exp_q.push_back(32'hA5);
    for (int i = 0; i < 12; i++) begin
      b = p[95 - 8*i -: 8];
      x = x ^ b;
      exp_q.push_back(int'(b));
    end
    exp_q.push_back(int'(x));
    exp_q.push_back(DONE_MARK);
  endtask

  task automatic set_inputs(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] dat);
    bus.i_pc          = pc;
    bus.i_instruction = ins;
    bus.i_data        = dat;
  endtask

  task automatic pulse_send();
    bus.i_send = 1'b1;
    @(posedge clk); #1;
    bus.i_send = 1'b0;
  endtask

  task automatic wait_starts(input int n);
    int k;
    k = 0;
    while (starts < n && k < 1000) begin
      @(posedge clk); #1;
      k++;
    end
    if (starts < n) fail("wait_starts_timeout");
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!bus.o_done && k < 600) begin
      @(posedge clk); #1;
      k++;
    end
    if (!bus.o_done) fail("wait_done_timeout");
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_start"}, int'(bus.o_tx_start), 0);
    check({tag, "_busy"},     int'(bus.o_busy),     0);
    check({tag, "_done"},     int'(bus.o_done),     0);
    check({tag, "_tx_data"},  int'(bus.o_tx_data),  0);
  endtask

  initial begin
    bus.i_send = 1'b0;
    set_inputs(32'h0, 32'h0, 32'h0);
    idle(3);
    check_reset_outputs("rst");
    rst = 1'b0;
    idle(20);
    check_reset_outputs("idle20");

    // Frame with hand-computed bytes; inputs disturbed during byte 6
    set_inputs(32'h0000_0004, 32'h2001_0005, 32'hDEAD_BEEF);
    foreach (exp_q[i]) ; // no-op guard on empty queue
    exp_q.push_back(32'hA5); exp_q.push_back(32'h00); exp_q.push_back(32'h00);
    exp_q.push_back(32'h00); exp_q.push_back(32'h04); exp_q.push_back(32'h20);
    exp_q.push_back(32'h01); exp_q.push_back(32'h00); exp_q.push_back(32'h05);
    exp_q.push_back(32'hDE); exp_q.push_back(32'hAD); exp_q.push_back(32'hBE);
    exp_q.push_back(32'hEF); exp_q.push_back(32'h02); exp_q.push_back(DONE_MARK);
    pulse_send();
    check("latency_start", int'(bus.o_tx_start), 1);
    check("latency_busy",  int'(bus.o_busy),     1);
    check("latency_hdr",   int'(bus.o_tx_data),  32'hA5);
    wait_starts(6);
    set_inputs(32'h1111_1111, 32'h2222_2222, 32'h3333_3333);
    pulse_send();
    wait_done();
    idle(40);
    check("s2_queue_drained", exp_q.size(), 0);
    check("s2_idle_busy", int'(bus.o_busy), 0);

    // Reset during WAIT of byte 7, then a fresh full frame
    set_inputs(32'h0000_0008, 32'h0022_1820, 32'h0000_0007);
    push_frame(32'h0000_0008, 32'h0022_1820, 32'h0000_0007);
    pulse_send();
    wait_starts(7);
    idle(3);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    idle(1);
    rst = 1'b0;
    idle(2);
    check("midrst_no_start", int'(bus.o_tx_start), 0);
    set_inputs(32'h0000_000C, 32'h0000_0000, 32'hFFFF_FFFF);
    push_frame(32'h0000_000C, 32'h0000_0000, 32'hFFFF_FFFF);
    pulse_send();
    wait_done();
    idle(20);
    check("s4_queue_drained", exp_q.size(), 0);

    // Held i_send: back-to-back frames with a new snapshot for the second
    set_inputs(32'h0000_0100, 32'h8C22_0010, 32'h1234_5678);
    push_frame(32'h0000_0100, 32'h8C22_0010, 32'h1234_5678);
    push_frame(32'h0000_0104, 32'hAC23_0014, 32'hCAFE_F00D);
    bus.i_send = 1'b1;
    wait_starts(1);
    set_inputs(32'h0000_0104, 32'hAC23_0014, 32'hCAFE_F00D);
    wait_done();
    idle(1);
    check("b2b_gap_start", int'(bus.o_tx_start), 0);
    check("b2b_gap_busy",  int'(bus.o_busy),     0);
    idle(1);
    check("b2b_next_start", int'(bus.o_tx_start), 1);
    check("b2b_next_hdr",   int'(bus.o_tx_data),  32'hA5);
    bus.i_send = 1'b0;
    wait_done();
    idle(30);
    check("s5_queue_drained", exp_q.size(), 0);

    // Spurious done ticks in IDLE and in the START cycle
    inj_tick = 1'b1;
    idle(1);
    inj_tick = 1'b0;
    check("spur_idle_busy",  int'(bus.o_busy),     0);
    check("spur_idle_start", int'(bus.o_tx_start), 0);
    set_inputs(32'h0000_0200, 32'h0800_0040, 32'h0F0F_55AA);
    push_frame(32'h0000_0200, 32'h0800_0040, 32'h0F0F_55AA);
    pulse_send();
    check("spur_in_start", int'(bus.o_tx_start), 1);
    inj_tick = 1'b1;
    idle(1);
    inj_tick = 1'b0;
    check("spur_after_start", int'(bus.o_tx_data), 32'hA5);
    wait_done();
    idle(30);
    check("s6_queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
